// File: rtl/serial_adder_if.sv
// Handshake and result bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow flag ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             bit_s;
    logic             carry_next;
    logic             last_bit;
    logic             accept;
    logic             busy;
    logic             done;

    always_comb begin
        bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        last_bit   = (cnt == CW'(WIDTH - 1));
        accept     = (state != RUN) && bus.start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = bus.start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {bit_s, res_sr[WIDTH-1:1]};
            carry  <= carry_next;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                sum_r  <= {bit_s, res_sr[WIDTH-1:1]};
                cout_r <= carry_next;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // On the last bit, carry holds the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            ovf_r <= 1'b0;
        else if (state == RUN && last_bit)  ovf_r <= carry ^ carry_next;
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 a  input  WIDTH  first operand; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  second operand; sampled only on the edge that accepts start.
REQ-007 sub  input  1  mode: 0 computes a+b, 1 computes a-b; sampled with a and b.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new valid result.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  carry out of bit WIDTH-1; for sub=1 this is the not-borrow flag.
REQ-012 ovf  output  1  signed overflow flag; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1: latch a, latch (sub ? ~b : b), set carry=sub, clear bit counter, enter RUN.
REQ-015 RUN: one full-adder bit per cycle, LSB first; sum bit = a_i^b_i^c; carry = a_i&b_i | c&(a_i^b_i).
REQ-016 RUN exits to DONE on the edge that processes bit WIDTH-1.
REQ-017 Operand registers shift right one bit per RUN cycle; the result shift register fills from the MSB.
REQ-018 sum and cout load only on RUN->DONE and hold until the next completion.
REQ-019 Intermediate shift-register contents never appear on sum.
REQ-020 Latency: if start is accepted on edge N, done is high from edge N+WIDTH to edge N+WIDTH+1.
REQ-021 busy = 1 exactly in RUN; done = 1 exactly in DONE.
REQ-022 DONE with start=0 returns to IDLE after one cycle.
REQ-023 DONE with start=1 accepts the new operation, enabling back-to-back throughput of one result per WIDTH+1 cycles.
REQ-024 start during RUN is ignored; the operation in flight and its operands are unaffected.
REQ-025 a, b and sub may change freely except on the accepting edge.
REQ-026 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-027 rst=1 forces, asynchronously, state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clears counter, carry and shift registers.
REQ-028 Reset during RUN aborts the operation; no done pulse occurs for the aborted operation.
REQ-029 After reset release, the first accepted start behaves as from power-up.

Configuration
REQ-030 Macro SERIAL_ADDER_OVF_EN.
REQ-031 When defined: port ovf exists; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; ovf updates with sum and holds with it.
REQ-032 When undefined: port ovf is absent, its logic is absent, and all other behaviour is identical.

Verification (WIDTH=8)
REQ-033 a=0x0F, b=0x01, sub=0, start on edge 0 -> busy for 8 cycles; done at edge 8; sum=0x10, cout=0.
REQ-034 a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1; with the macro, ovf=0. a=0x7F, b=0x01 -> sum=0x80, ovf=1.
REQ-035 a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0. a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
REQ-036 start held with a=0x11, b=0x22, then new start with a=0xAA, b=0x55 on the DONE cycle:
- start pulsed with different operands mid-RUN -> ignored; first result 0x33.
- second result 0xFF, cout=0, with its done pulse 9 cycles after the first.
REQ-037 rst asserted at RUN cycle 4 between edges -> busy=0, sum=0 immediately, no done pulse; next operation correct.
REQ-038 Random a, b, sub over WIDTH in {2, 8, 33}, 1000 operations -> sum and cout match the reference model on every done.
